// File: rtl/sd_cmd_line_engine.sv
// SD CMD line engine: serialises a 48-bit command frame with CRC7, then receives and checks the card response.
// Build option SD_CMD_BUSY_WAIT_EN adds dat0_in and a DAT0 busy wait after R1b (type 11) responses.
module sd_cmd_line_engine #(
    parameter int NCR_MAX  = 64,
    parameter int TURN_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_in,
    input  logic [5:0]   CommandIndex_in,
    input  logic [31:0]  Argument_in,
    input  logic [1:0]   ResponseTypeSelect_in,
    input  logic         CommandIndexCheckEnable_in,
    input  logic         CommandCRCCheckEnable_in,
    input  logic         cmd_in,
`ifdef SD_CMD_BUSY_WAIT_EN
    input  logic         dat0_in,
`endif
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         busy_out,
    output logic         cmd_complete_out,
    output logic         timeout_err_out,
    output logic         crc_err_out,
    output logic         index_err_out,
    output logic         endbit_err_out,
    output logic [127:0] response_out
);

    localparam int WCW = (NCR_MAX > 1) ? $clog2(NCR_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_TURN,
        S_WAIT_START,
        S_RX,
        S_CHECK,
        S_BUSY,
        S_DONE
    } state_t;

    // One LFSR step of CRC7, generator x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_calc(input logic [39:0] data);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, data[i]);
        end
        return c;
    endfunction

    state_t         r_state;
    logic [7:0]     r_bit_cnt;
    logic [WCW-1:0] r_wait_cnt;
    logic [46:0]    r_tx_sr;
    logic [5:0]     r_idx;
    logic [1:0]     r_rtype;
    logic           r_idx_chk;
    logic           r_crc_chk;
    logic [127:0]   r_rx_sr;
    logic [6:0]     r_rx_crc;
    logic           r_cmd_out;
    logic           r_cmd_oe;
    logic           r_busy;
    logic           r_complete;
    logic           r_timeout;
    logic           r_crc_err;
    logic           r_idx_err;
    logic           r_end_err;
    logic [127:0]   r_resp;

    logic [39:0]    w_tx_data;
    logic [47:0]    w_tx_frame;
    logic           w_rx_long;
    logic [7:0]     w_rx_last;
    logic           w_rx_crc_bit;
    logic           w_rx_crc_ok;
    logic           w_idx_mismatch;
    logic [127:0]   w_resp;

    assign w_tx_data  = {2'b01, CommandIndex_in, Argument_in};
    assign w_tx_frame = {w_tx_data, crc7_calc(w_tx_data), 1'b1};

    // r_bit_cnt counts received bits including the start bit; the CRC window
    // differs because R2 excludes its leading start/transmission/reserved byte.
    assign w_rx_long      = (r_rtype == 2'b01);
    assign w_rx_last      = w_rx_long ? 8'd135 : 8'd47;
    assign w_rx_crc_bit   = w_rx_long ? ((r_bit_cnt >= 8'd8) && (r_bit_cnt < 8'd128))
                                      : (r_bit_cnt < 8'd40);
    assign w_rx_crc_ok    = (r_rx_crc == r_rx_sr[7:1]);
    assign w_idx_mismatch = !w_rx_long && r_idx_chk && (r_rx_sr[45:40] != r_idx);
    assign w_resp         = w_rx_long ? {8'h00, r_rx_sr[127:8]} : {96'h0, r_rx_sr[39:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 8'd0;
            r_wait_cnt <= '0;
            r_tx_sr    <= '1;
            r_idx      <= 6'd0;
            r_rtype    <= 2'b00;
            r_idx_chk  <= 1'b0;
            r_crc_chk  <= 1'b0;
            r_rx_sr    <= '0;
            r_rx_crc   <= 7'd0;
            r_cmd_out  <= 1'b1;
            r_cmd_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
            r_timeout  <= 1'b0;
            r_crc_err  <= 1'b0;
            r_idx_err  <= 1'b0;
            r_end_err  <= 1'b0;
            r_resp     <= '0;
        end else begin
            r_complete <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_idx     <= CommandIndex_in;
                        r_rtype   <= ResponseTypeSelect_in;
                        r_idx_chk <= CommandIndexCheckEnable_in;
                        r_crc_chk <= CommandCRCCheckEnable_in;
                        r_tx_sr   <= w_tx_frame[46:0];
                        r_cmd_out <= w_tx_frame[47];
                        r_cmd_oe  <= 1'b1;
                        r_bit_cnt <= 8'd47;
                        r_busy    <= 1'b1;
                        r_timeout <= 1'b0;
                        r_crc_err <= 1'b0;
                        r_idx_err <= 1'b0;
                        r_end_err <= 1'b0;
                        r_state   <= S_TX;
                    end
                end

                // r_bit_cnt holds the number of frame bits still to follow the one on the line.
                S_TX: begin
                    if (r_bit_cnt == 8'd0) begin
                        r_cmd_oe  <= 1'b0;
                        r_cmd_out <= 1'b1;
                        if (r_rtype == 2'b00) begin
                            r_complete <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (TURN_CYC == 0) begin
                            r_wait_cnt <= '0;
                            r_state    <= S_WAIT_START;
                        end else begin
                            r_bit_cnt <= 8'(TURN_CYC - 1);
                            r_state   <= S_TURN;
                        end
                    end else begin
                        r_cmd_out <= r_tx_sr[46];
                        r_tx_sr   <= {r_tx_sr[45:0], 1'b1};
                        r_bit_cnt <= r_bit_cnt - 8'd1;
                    end
                end

                S_TURN: begin
                    if (r_bit_cnt == 8'd0) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT_START;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 8'd1;
                    end
                end

                // The start bit contributes a zero to both the shift register and the CRC.
                S_WAIT_START: begin
                    if (!cmd_in) begin
                        r_rx_sr   <= '0;
                        r_rx_crc  <= 7'd0;
                        r_bit_cnt <= 8'd1;
                        r_state   <= S_RX;
                    end else if (r_wait_cnt == WCW'(NCR_MAX - 1)) begin
                        r_timeout  <= 1'b1;
                        r_complete <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                S_RX: begin
                    r_rx_sr <= {r_rx_sr[126:0], cmd_in};
                    if (w_rx_crc_bit) begin
                        r_rx_crc <= crc7_step(r_rx_crc, cmd_in);
                    end
                    if (r_bit_cnt == w_rx_last) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                    end
                end

                S_CHECK: begin
                    r_resp    <= w_resp;
                    r_crc_err <= r_crc_chk && !w_rx_crc_ok;
                    r_idx_err <= w_idx_mismatch;
                    r_end_err <= !r_rx_sr[0];
`ifdef SD_CMD_BUSY_WAIT_EN
                    if (r_rtype == 2'b11) begin
                        r_state <= S_BUSY;
                    end else begin
                        r_complete <= 1'b1;
                        r_state    <= S_DONE;
                    end
`else
                    r_complete <= 1'b1;
                    r_state    <= S_DONE;
`endif
                end

`ifdef SD_CMD_BUSY_WAIT_EN
                S_BUSY: begin
                    if (dat0_in) begin
                        r_complete <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_out          = r_cmd_out;
    assign cmd_oe           = r_cmd_oe;
    assign busy_out         = r_busy;
    assign cmd_complete_out = r_complete;
    assign timeout_err_out  = r_timeout;
    assign crc_err_out      = r_crc_err;
    assign index_err_out    = r_idx_err;
    assign endbit_err_out   = r_end_err;
    assign response_out     = r_resp;

endmodule

// File: doc/sd_cmd_line_engine.md
Name: sd_cmd_line_engine

Overview:
- Consumes a command decoded from the Command register (index, type, response type, check enables) plus the 32-bit Argument register.
- Serializes the 48-bit SD command frame onto the CMD line, generating CRC7.
- Receives and checks the card response, then reports completion and error status to the interrupt/response registers.
- Sits between the register file and the SD pad CMD tri-state. One bit is transferred per clk, so clk is the SD card clock domain.

Parameters:
- NCR_MAX, 64, max cycles spent waiting for the response start bit before a timeout.
- TURN_CYC, 2, idle cycles between the transmitted end bit and the start of response sampling.

Ports:
- clk  input  1  SD clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start_in  input  1  one-cycle pulse to issue a command; ignored while busy_out=1.
- CommandIndex_in  input  6  command index, CMD0..CMD63.
- Argument_in  input  32  command argument.
- ResponseTypeSelect_in  input  2  00 none, 01 136-bit, 10 48-bit, 11 48-bit with busy.
- CommandIndexCheckEnable_in  input  1  compare response index with the command index.
- CommandCRCCheckEnable_in  input  1  check response CRC7.
- cmd_in  input  1  CMD pad input.
- cmd_out  output  1  CMD pad output data.
- cmd_oe  output  1  CMD pad output enable.
- busy_out  output  1  high from the cycle after start is accepted until the cycle of cmd_complete_out.
- cmd_complete_out  output  1  one-cycle pulse when the command ends, with or without error.
- timeout_err_out  output  1  valid with complete; held until the next start.
- crc_err_out  output  1  same timing as timeout_err_out.
- index_err_out  output  1  same timing as timeout_err_out.
- endbit_err_out  output  1  same timing as timeout_err_out.
- response_out  output  128  captured response; held until the next start.

Behaviour:
- Reset values: cmd_out=1, cmd_oe=0, busy_out=0, cmd_complete_out=0, all error outputs 0, response_out=0, FSM in IDLE.
- Reset asserted in any state returns to IDLE next cycle; the command is aborted and no complete pulse is issued.
- Frame layout, sent MSB first, bit 47 first:
  - bit 47 = 0 (start), bit 46 = 1 (transmission).
  - bits 45:40 = index, bits 39:8 = argument.
  - bits 7:1 = CRC7 over bits 47..8, polynomial x^7+x^3+1, initial value 0.
  - bit 0 = 1 (end).
- FSM states: IDLE, TX, TURN, WAIT_START, RX, CHECK, BUSY (optional), DONE.
- IDLE:
  - On start_in, latch all inputs, clear the error outputs, set busy.
  - Go to TX; bit 47 appears on cmd_out with cmd_oe=1 on the cycle after start.
- TX: 48 cycles, one bit per cycle.
  - After bit 0, cmd_oe=0 and cmd_out=1.
  - Response type 00: go to DONE.
  - Otherwise go to TURN.
- TURN: TURN_CYC cycles with cmd_in ignored, then go to WAIT_START with the counter cleared.
- WAIT_START:
  - Sample cmd_in each cycle; the first 0 is the start bit and moves to RX.
  - If the counter reaches NCR_MAX with no 0 seen, set timeout_err and go to DONE.
- RX: shift in the remaining bits (47 for 48-bit, 135 for 136-bit), then go to CHECK.
- CHECK, one cycle:
  - 48-bit response:
    - response_out[31:0] = R[39:8], upper bits 0.
    - CRC is over R[47:8].
    - index_err if the check is enabled and R[45:40] != latched index.
  - 136-bit response:
    - response_out[119:0] = R[127:8], upper bits 0.
    - CRC is over R[127:8].
    - Index check is never applied.
  - crc_err only if the CRC check is enabled and the CRC mismatches.
  - endbit_err if R[0] != 1.
  - Type 11 goes to BUSY when the feature is compiled in; otherwise go to DONE.
- DONE: pulse cmd_complete_out for 1 cycle, clear busy, return to IDLE.
  - A start_in in the same cycle as DONE is ignored.
  - A new start is accepted the following cycle.
- Errors do not abort the response capture. response_out is updated even on CRC, index or end-bit error; on timeout it is unchanged.

Optional Feature:
- Macro: SD_CMD_BUSY_WAIT_EN.
- Defined:
  - Adds input dat0_in (1 bit).
  - After CHECK for type 11, stay in BUSY while dat0_in=0, then go to DONE on the first cycle with dat0_in=1.
  - There is no busy timeout.
- Undefined: no dat0_in port, and type 11 behaves exactly like type 10.

Test Plan:
- CMD0, arg 0x00000000, type 00:
  - cmd_out serially = 0x40_00000000_95 starting 1 cycle after start, cmd_oe high for exactly 48 cycles.
  - cmd_complete_out 1 cycle after the end bit, no errors.
- CMD8, arg 0x000001AA, type 10, both checks on:
  - Transmitted frame 0x48_000001AA_87.
  - Card drives 0x08_000001AA_13 after 5 idle cycles, giving response_out=0x000001AA with no errors.
- Same as the previous case, but the card returns index 0x09 (frame 0x09_000001AA_xx with a correct CRC):
  - index_err_out=1, crc_err_out=0.
  - With the index check disabled: no error.
- Type 10 with cmd_in held at 1:
  - timeout_err_out=1 and complete exactly NCR_MAX cycles after TURN ends.
  - response_out is unchanged from its prior value.
- Corrupted response bit 20 with the CRC check on: crc_err_out=1. With the CRC check off: no error.
- rst pulsed at TX bit 30:
  - Next cycle cmd_oe=0, cmd_out=1, busy_out=0, and no complete pulse.
  - A fresh CMD0 afterwards transmits correctly.
